// File: rtl/ram_port_scheduler.sv
// rtl/ram_port_scheduler.sv - single RAM port scheduler for one write, four reads and a DMA master
`timescale 1ns/1ps
module ram_port_scheduler #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic [3:0]        rd_req,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [ADDR_W-1:0] rd_addr3,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] rd_data3,
    output logic [3:0]        rd_ready,
    output logic              stall,
    input  logic              dma_req,
    output logic              dma_grant,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_read,
    input  logic              dma_write,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              cpu_prio,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RWAIT, S_DMA} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        port;
    logic [1:0]        port_nxt;
    logic [1:0]        lat_cnt;
    logic [ADDR_W-1:0] sel_rd_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              read_q;
    logic              write_q;
    logic              wr_pend;
    logic [3:0]        rd_pend;
    logic              any_pend;
    logic              go_wr;
    logic              go_rd;
    logic              rd_done;
    logic              cpu_done;

    // A request is pending until its ready flag answers it; the processor stalls on any pending one.
    assign wr_pend  = wr_req & ~wr_ready;
    assign rd_pend  = rd_req & ~rd_ready;
    assign any_pend = wr_pend | (|rd_pend);
    assign stall    = any_pend;

    assign go_wr    = (state == S_IDLE) && (state_nxt == S_WR);
    assign go_rd    = (state == S_IDLE) && (state_nxt == S_RD);
    assign rd_done  = (state == S_RWAIT) && (lat_cnt == 2'd0);
    assign cpu_done = (state == S_WR) || rd_done;

    // The DMA master drives the RAM directly while it holds the grant.
    assign ram_addr  = dma_grant ? dma_addr  : addr_q;
    assign ram_wdata = dma_grant ? dma_wdata : wdata_q;
    assign ram_read  = dma_grant ? dma_read  : read_q;
    assign ram_write = dma_grant ? dma_write : write_q;
    assign dma_rdata = ram_rdata;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration in IDLE: DMA on idle processor or lost priority, then write ahead of reads, low read index first.
    always_comb begin
        state_nxt   = state;
        port_nxt    = 2'd0;
        sel_rd_addr = rd_addr0;
        for (int i = 3; i >= 0; i--) begin
            if (rd_pend[i]) begin
                port_nxt = 2'(i);
            end
        end
        case (port_nxt)
            2'd0:    sel_rd_addr = rd_addr0;
            2'd1:    sel_rd_addr = rd_addr1;
            2'd2:    sel_rd_addr = rd_addr2;
            default: sel_rd_addr = rd_addr3;
        endcase
        case (state)
            S_IDLE: begin
                if (dma_req && (!any_pend || !cpu_prio)) begin
                    state_nxt = S_DMA;
                end else if (wr_pend) begin
                    state_nxt = S_WR;
                end else if (|rd_pend) begin
                    state_nxt = S_RD;
                end
            end
            S_WR:    state_nxt = S_IDLE;
            S_RD:    state_nxt = S_RWAIT;
            S_RWAIT: if (lat_cnt == 2'd0) state_nxt = S_IDLE;
            S_DMA:   if (!dma_req) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // RAM strobes, address/data hold registers and read latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            port    <= 2'd0;
            lat_cnt <= 2'd0;
        end else begin
            write_q <= go_wr;
            read_q  <= go_rd;
            if (go_wr) begin
                addr_q  <= wr_addr;
                wdata_q <= wr_data;
            end else if (go_rd) begin
                addr_q <= sel_rd_addr;
                port   <= port_nxt;
            end else if (dma_grant) begin
                addr_q  <= dma_addr;
                wdata_q <= dma_wdata;
            end
            if (state == S_RD) begin
                lat_cnt <= 2'(RD_LAT - 1);
            end else if ((state == S_RWAIT) && (lat_cnt != 2'd0)) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
        end
    end

    // Ready flags, captured read data, grant and the alternating priority bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ready  <= 1'b0;
            rd_ready  <= 4'b0;
            rd_data0  <= '0;
            rd_data1  <= '0;
            rd_data2  <= '0;
            rd_data3  <= '0;
            dma_grant <= 1'b0;
            cpu_prio  <= 1'b1;
        end else begin
            wr_ready  <= (wr_ready & wr_req) | (state == S_WR);
            rd_ready  <= (rd_ready & rd_req) | (rd_done ? (4'b0001 << port) : 4'b0000);
            dma_grant <= (state_nxt == S_DMA);
            if (rd_done) begin
                case (port)
                    2'd0:    rd_data0 <= ram_rdata;
                    2'd1:    rd_data1 <= ram_rdata;
                    2'd2:    rd_data2 <= ram_rdata;
                    default: rd_data3 <= ram_rdata;
                endcase
            end
            if ((state == S_DMA) && !dma_req) begin
                cpu_prio <= 1'b1;
            end else if (cpu_done && dma_req) begin
                cpu_prio <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_scheduler.sv
// tb/tb_ram_port_scheduler.sv - self-checking bench for ram_port_scheduler
`timescale 1ns/1ps
module tb_ram_port_scheduler;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 10;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic [3:0]        rd_req = 4'b0;
    logic [ADDR_W-1:0] ra [4];
    logic [DATA_W-1:0] rdd [4];
    logic [3:0]        rd_ready;
    logic              stall;
    logic              dma_req = 1'b0;
    logic              dma_grant;
    logic [ADDR_W-1:0] dma_addr = '0;
    logic [DATA_W-1:0] dma_wdata = '0;
    logic              dma_read = 1'b0;
    logic              dma_write = 1'b0;
    logic [DATA_W-1:0] dma_rdata;
    logic              cpu_prio;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_read;
    logic              ram_write;
    logic [DATA_W-1:0] ram_rdata = '0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int total = 0;
    int passed = 0;

    ram_port_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req),
        .rd_addr0(ra[0]), .rd_addr1(ra[1]), .rd_addr2(ra[2]), .rd_addr3(ra[3]),
        .rd_data0(rdd[0]), .rd_data1(rdd[1]), .rd_data2(rdd[2]), .rd_data3(rdd[3]),
        .rd_ready(rd_ready), .stall(stall),
        .dma_req(dma_req), .dma_grant(dma_grant), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_read(dma_read), .dma_write(dma_write), .dma_rdata(dma_rdata), .cpu_prio(cpu_prio),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_read(ram_read), .ram_write(ram_write),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_wdata;
        if (ram_read) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else passed++;
    endtask

    typedef struct {
        logic              is_wr;
        int                port;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                lat;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int cyc;
        int fw;
        int fr [4];
        int sc;
        vec_t v;

        tbl[0] = '{1'b1, 0, 14'h0005, 10'h2A3, 2};
        tbl[1] = '{1'b0, 0, 14'h0005, 10'h2A3, 3};
        tbl[2] = '{1'b1, 0, 14'h3FFF, 10'h1C7, 2};
        tbl[3] = '{1'b0, 3, 14'h3FFF, 10'h1C7, 3};
        tbl[4] = '{1'b1, 0, 14'h0000, 10'h001, 2};
        tbl[5] = '{1'b0, 1, 14'h0000, 10'h001, 3};
        tbl[6] = '{1'b0, 2, 14'h0005, 10'h2A3, 3};
        tbl[7] = '{1'b1, 0, 14'h1234, 10'h155, 2};
        tbl[8] = '{1'b0, 2, 14'h1234, 10'h155, 3};
        for (int i = 0; i < 4; i++) ra[i] = '0;

        // reset values
        #12;
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_dma_grant", dma_grant, 0);
        chk("rst_ram_read", ram_read, 0);
        chk("rst_ram_write", ram_write, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_rd_data0", rdd[0], 0);
        chk("rst_rd_data3", rdd[3], 0);
        chk("rst_cpu_prio", cpu_prio, 1);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // table-driven single accesses
        for (int n = 0; n < 9; n++) begin
            v = tbl[n];
            @(negedge clk);
            if (v.is_wr) begin
                wr_addr = v.addr; wr_data = v.data; wr_req = 1'b1;
            end else begin
                ra[v.port] = v.addr; rd_req[v.port] = 1'b1;
            end
            #1;
            chk("vec_stall_up", stall, 1);
            @(posedge clk); #1;
            if (v.is_wr) begin
                chk("vec_ram_write", ram_write, 1);
                chk("vec_ram_wdata", ram_wdata, v.data);
            end else begin
                chk("vec_ram_read", ram_read, 1);
            end
            chk("vec_ram_addr", ram_addr, v.addr);
            cyc = 1;
            while (!(v.is_wr ? wr_ready : rd_ready[v.port]) && cyc < 20) begin
                @(posedge clk); #1; cyc++;
            end
            chk("vec_latency", cyc, v.lat);
            chk("vec_stall_down", stall, 0);
            if (!v.is_wr) chk("vec_rd_data", rdd[v.port], v.data);
            @(negedge clk);
            wr_req = 1'b0; rd_req = 4'b0;
            @(posedge clk); #1;
            chk("vec_ready_clear", {wr_ready, rd_ready}, 0);
        end

        // write then two reads of the same address, all requested together
        @(negedge clk);
        wr_addr = 14'h0010; wr_data = 10'h155; ra[0] = 14'h0010; ra[1] = 14'h0010;
        wr_req = 1'b1; rd_req = 4'b0011;
        fw = -1; fr[0] = -1; fr[1] = -1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (wr_ready && fw < 0) fw = c;
            if (rd_ready[0] && fr[0] < 0) fr[0] = c;
            if (rd_ready[1] && fr[1] < 0) fr[1] = c;
        end
        chk("raw_wr_first", fw, 2);
        chk("raw_rd0_second", fr[0], 5);
        chk("raw_rd1_third", fr[1], 8);
        chk("raw_rd_data0", rdd[0], 10'h155);
        chk("raw_rd_data1", rdd[1], 10'h155);
        chk("raw_wr_ready_held", wr_ready, 1);
        @(negedge clk);
        wr_req = 1'b0; rd_req = 4'b0;
        @(posedge clk);

        // all five ports at once
        @(negedge clk);
        wr_addr = 14'h0020; wr_data = 10'h0AA;
        ra[0] = 14'h0005; ra[1] = 14'h0010; ra[2] = 14'h0020; ra[3] = 14'h3FFF;
        wr_req = 1'b1; rd_req = 4'b1111;
        #1;
        fw = -1; sc = 0;
        for (int p = 0; p < 4; p++) fr[p] = -1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (stall) sc++;
            if (wr_ready && fw < 0) fw = c;
            for (int p = 0; p < 4; p++) if (rd_ready[p] && fr[p] < 0) fr[p] = c;
        end
        chk("all_wr", fw, 2);
        chk("all_rd0", fr[0], 5);
        chk("all_rd1", fr[1], 8);
        chk("all_rd2", fr[2], 11);
        chk("all_rd3", fr[3], 14);
        chk("all_stall_cycles", sc, 14);
        chk("all_data0", rdd[0], 10'h2A3);
        chk("all_data1", rdd[1], 10'h155);
        chk("all_data2", rdd[2], 10'h0AA);
        chk("all_data3", rdd[3], 10'h1C7);
        @(negedge clk);
        wr_req = 1'b0; rd_req = 4'b0;
        @(posedge clk);

        // DMA tenure with a processor write waiting behind it
        @(negedge clk);
        dma_req = 1'b1;
        @(posedge clk); #1;
        chk("dma_grant_rise", dma_grant, 1);
        @(negedge clk);
        dma_addr = 14'h3FFF; dma_wdata = 10'h3FF; dma_write = 1'b1;
        wr_addr = 14'h0100; wr_data = 10'h0CC; wr_req = 1'b1;
        #1;
        chk("dma_pass_write", ram_write, 1);
        chk("dma_pass_addr", ram_addr, 14'h3FFF);
        chk("dma_pass_wdata", ram_wdata, 10'h3FF);
        chk("dma_cpu_stall", stall, 1);
        @(negedge clk);
        dma_write = 1'b0; dma_read = 1'b1; dma_addr = 14'h0005;
        #1;
        chk("dma_pass_read", ram_read, 1);
        @(negedge clk);
        dma_read = 1'b0;
        #1;
        chk("dma_rdata", dma_rdata, 10'h2A3);
        chk("dma_wr_blocked", wr_ready, 0);
        dma_req = 1'b0;
        @(posedge clk); #1;
        chk("dma_grant_drop", dma_grant, 0);
        chk("dma_prio_back", cpu_prio, 1);
        cyc = 0;
        while (!wr_ready && cyc < 10) begin @(posedge clk); #1; cyc++; end
        chk("dma_wr_after", cyc, 2);
        @(negedge clk);
        wr_req = 1'b0; ra[0] = 14'h3FFF; rd_req = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        chk("dma_write_landed_rdy", rd_ready, 4'b0001);
        chk("dma_write_landed", rdd[0], 10'h3FF);
        @(negedge clk);
        rd_req = 4'b0;
        @(posedge clk);

        // contention: processor first, then DMA, then processor, then DMA
        @(negedge clk);
        ra[0] = 14'h0005; rd_req = 4'b0001; dma_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("cont_cpu_first", rd_ready, 4'b0001);
        chk("cont_cpu_data", rdd[0], 10'h2A3);
        chk("cont_prio_cleared", cpu_prio, 0);
        chk("cont_no_grant_yet", dma_grant, 0);
        @(negedge clk);
        ra[1] = 14'h0010; rd_req = 4'b0010;
        @(posedge clk); #1;
        chk("cont_dma_second", dma_grant, 1);
        chk("cont_cpu_stalled", stall, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("cont_dma_held", dma_grant, 1);
        chk("cont_rd1_waits", rd_ready, 4'b0000);
        @(negedge clk);
        dma_req = 1'b0;
        @(posedge clk); #1;
        chk("cont_grant_drop", dma_grant, 0);
        chk("cont_prio_set", cpu_prio, 1);
        @(negedge clk);
        dma_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("cont_cpu_third", rd_ready, 4'b0010);
        chk("cont_cpu_third_data", rdd[1], 10'h155);
        chk("cont_prio_cleared2", cpu_prio, 0);
        chk("cont_no_grant2", dma_grant, 0);
        @(posedge clk); #1;
        chk("cont_dma_fourth", dma_grant, 1);
        @(negedge clk);
        dma_req = 1'b0; rd_req = 4'b0;
        @(posedge clk); #1;
        chk("cont_final_drop", dma_grant, 0);
        @(posedge clk);

        // reset while waiting for read data
        @(negedge clk);
        ra[0] = 14'h0005; rd_req = 4'b0001;
        @(posedge clk); #1;
        chk("rw_ram_read", ram_read, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rw_rst_ready", rd_ready, 0);
        chk("rw_rst_ram_read", ram_read, 0);
        chk("rw_rst_ram_addr", ram_addr, 0);
        chk("rw_rst_data0", rdd[0], 0);
        chk("rw_rst_prio", cpu_prio, 1);
        chk("rw_rst_stall", stall, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rw_retry_ready", rd_ready, 4'b0001);
        chk("rw_retry_data", rdd[0], 10'h2A3);
        @(negedge clk);
        rd_req = 4'b0;
        @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
